// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (I) and load/store (D).
// Optional response watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                i_req_i,
   input  logic [ADDR_W-1:0]   i_addr_i,
   output logic                i_gnt_o,
   output logic                i_rvalid_o,
   output logic [DATA_W-1:0]   i_rdata_o,
   input  logic                d_req_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   output logic                d_gnt_o,
   output logic                d_rvalid_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                mem_req_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                err_o
);

   localparam int BE_W = DATA_W / 8;
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("mem_port_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q;
   logic                owner_i_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [SC_W-1:0]     starve_q;
   logic [SC_W-1:0]     starve_d;

   logic                any_req;
   logic                i_forced;
   logic                i_wins;
   logic                gnt_evt;
   logic                rsp_evt;
   logic                timeout;
   logic [DATA_W-1:0]   rsp_data;

   // Handshake: a requester holds req until its gnt pulse; memory sees mem_req_o held
   // until mem_gnt_i, then returns exactly one mem_rvalid_i, forwarded as the owner's rvalid pulse.
   assign any_req  = i_req_i | d_req_i;
   assign i_forced = i_req_i && (starve_q >= SC_W'(STARVE_LIMIT));
   assign i_wins   = i_req_i && (!d_req_i || i_forced);
   assign gnt_evt  = (state_q == ST_REQ) && mem_gnt_i;
   assign rsp_evt  = (state_q == ST_RESP) && (mem_rvalid_i || timeout);
   assign rsp_data = timeout ? DATA_W'(32'hDEAD_BEEF) : mem_rdata_i;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt_q;

   assign timeout = (state_q == ST_RESP) && !mem_rvalid_i
                    && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wd_cnt_q <= '0;
      end else if (gnt_evt) begin
         wd_cnt_q <= '0;
      end else if (state_q == ST_RESP) begin
         wd_cnt_q <= wd_cnt_q + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign err_o       = timeout;
   assign mem_req_o   = (state_q == ST_REQ);
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
   assign i_gnt_o     = gnt_evt && owner_i_q;
   assign d_gnt_o     = gnt_evt && !owner_i_q;
   assign i_rvalid_o  = rsp_evt && owner_i_q;
   assign d_rvalid_o  = rsp_evt && !owner_i_q;
   assign i_rdata_o   = i_rvalid_o ? rsp_data : '0;
   assign d_rdata_o   = d_rvalid_o ? rsp_data : '0;

   // I's waiting time; winning arbitration in IDLE is not counted as waiting.
   always_comb begin
      starve_d = starve_q;
      if (i_gnt_o) begin
         starve_d = '0;
      end else if (state_q == ST_IDLE && !i_req_i) begin
         starve_d = '0;
      end else if (i_req_i && !(state_q == ST_IDLE && i_wins)
                   && starve_q < SC_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         owner_i_q <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         starve_q  <= '0;
      end else begin
         starve_q <= starve_d;
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  owner_i_q <= i_wins;
                  addr_q    <= i_wins ? i_addr_i : d_addr_i;
                  be_q      <= i_wins ? '0 : d_be_i;
                  wdata_q   <= i_wins ? '0 : d_wdata_i;
                  state_q   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_gnt_i) state_q <= ST_RESP;
            end
            ST_RESP: begin
               if (mem_rvalid_i || timeout) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked cycle by cycle
// against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int ADDR_W         = 32;
   localparam int DATA_W         = 32;
   localparam int BE_W           = DATA_W / 8;
   localparam int STARVE_LIMIT   = 4;
   localparam int TIMEOUT_CYCLES = 8;

   logic              clk_i = 1'b0;
   logic              rst_n_i;
   logic              i_req_i;
   logic [ADDR_W-1:0] i_addr_i;
   logic              i_gnt_o, i_rvalid_o;
   logic [DATA_W-1:0] i_rdata_o;
   logic              d_req_i;
   logic [BE_W-1:0]   d_be_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic              d_gnt_o, d_rvalid_o;
   logic [DATA_W-1:0] d_rdata_o;
   logic              mem_req_o;
   logic [BE_W-1:0]   mem_be_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_gnt_i, mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              err_o;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
      .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: one transaction in flight, plus I's accumulated waiting time
   bit                m_busy, m_granted, m_own_i;
   logic [ADDR_W-1:0] m_addr;
   logic [BE_W-1:0]   m_be;
   logic [DATA_W-1:0] m_wdata;
   int                m_wait, m_resp_cycles;

   int                mem_mode;   // 0 manual, 1 immediate responder, 2 random
   logic [DATA_W-1:0] mem_fix;
   bit                last_i_gnt, last_d_gnt;
   int                obs_i_gnt, obs_d_gnt, obs_i_rv, obs_d_rv, obs_err;
   logic [DATA_W-1:0] obs_i_rdata, obs_d_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_busy = 0; m_granted = 0; m_own_i = 0;
      m_addr = '0; m_be = '0; m_wdata = '0;
      m_wait = 0; m_resp_cycles = 0;
   endtask

   task automatic clear_obs();
      obs_i_gnt = 0; obs_d_gnt = 0; obs_i_rv = 0; obs_d_rv = 0; obs_err = 0;
      obs_i_rdata = '0; obs_d_rdata = '0;
   endtask

   task automatic check_zero(input string p);
      check({p, "_mem_req_o"},   mem_req_o,   0);
      check({p, "_mem_be_o"},    mem_be_o,    0);
      check({p, "_mem_addr_o"},  mem_addr_o,  0);
      check({p, "_mem_wdata_o"}, mem_wdata_o, 0);
      check({p, "_i_gnt_o"},     i_gnt_o,     0);
      check({p, "_i_rvalid_o"},  i_rvalid_o,  0);
      check({p, "_i_rdata_o"},   i_rdata_o,   0);
      check({p, "_d_gnt_o"},     d_gnt_o,     0);
      check({p, "_d_rvalid_o"},  d_rvalid_o,  0);
      check({p, "_d_rdata_o"},   d_rdata_o,   0);
      check({p, "_err_o"},       err_o,       0);
   endtask

   // Entered at posedge+1 with requester inputs set; returns at the next posedge+1.
   task automatic cycle();
      bit idle, in_req, in_resp, to, rsp, i_wins, e_ig, e_dg, e_ir, e_dr;
      logic [DATA_W-1:0] e_rd;
      idle    = !m_busy;
      in_req  = m_busy && !m_granted;
      in_resp = m_busy && m_granted;
      case (mem_mode)
         1: begin mem_gnt_i = in_req; mem_rvalid_i = in_resp; mem_rdata_i = mem_fix; end
         2: begin
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = 1'($urandom_range(0, 1));
            mem_rdata_i  = $urandom;
         end
         default: ;
      endcase
      @(negedge clk_i);
      to = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to = in_resp && !mem_rvalid_i && (m_resp_cycles == TIMEOUT_CYCLES - 1);
`endif
      rsp  = in_resp && (mem_rvalid_i || to);
      e_rd = to ? 32'hDEAD_BEEF : mem_rdata_i;
      e_ig = in_req && mem_gnt_i && m_own_i;
      e_dg = in_req && mem_gnt_i && !m_own_i;
      e_ir = rsp && m_own_i;
      e_dr = rsp && !m_own_i;
      check("mem_req_o",  mem_req_o,  in_req);
      check("mem_addr_o", mem_addr_o, m_addr);
      check("mem_be_o",   mem_be_o,   m_be);
      if (!m_own_i) check("mem_wdata_o", mem_wdata_o, m_wdata);
      check("i_gnt_o",    i_gnt_o,    e_ig);
      check("d_gnt_o",    d_gnt_o,    e_dg);
      check("i_rvalid_o", i_rvalid_o, e_ir);
      check("d_rvalid_o", d_rvalid_o, e_dr);
      if (e_ir) check("i_rdata_o", i_rdata_o, e_rd);
      if (e_dr) check("d_rdata_o", d_rdata_o, e_rd);
      if (m_own_i) check("d_rdata_o_nonowner", d_rdata_o, 0);
      else         check("i_rdata_o_nonowner", i_rdata_o, 0);
      check("err_o", err_o, to);
      obs_i_gnt += int'(i_gnt_o);
      obs_d_gnt += int'(d_gnt_o);
      obs_i_rv  += int'(i_rvalid_o);
      obs_d_rv  += int'(d_rvalid_o);
      obs_err   += int'(err_o);
      if (i_rvalid_o) obs_i_rdata = i_rdata_o;
      if (d_rvalid_o) obs_d_rdata = d_rdata_o;
      last_i_gnt = e_ig;
      last_d_gnt = e_dg;
      i_wins = idle && i_req_i && (!d_req_i || m_wait >= STARVE_LIMIT);
      if (e_ig) m_wait = 0;
      else if (idle && !i_req_i) m_wait = 0;
      else if (i_req_i && !i_wins && m_wait < STARVE_LIMIT) m_wait++;
      if (idle && (i_req_i || d_req_i)) begin
         m_own_i = i_wins;
         m_addr  = i_wins ? i_addr_i : d_addr_i;
         m_be    = i_wins ? '0 : d_be_i;
         m_wdata = i_wins ? '0 : d_wdata_i;
         m_busy  = 1; m_granted = 0;
      end else if (in_req && mem_gnt_i) begin
         m_granted = 1; m_resp_cycles = 0;
      end else if (rsp) begin
         m_busy = 0;
      end else if (in_resp) begin
         m_resp_cycles++;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      mem_mode = 1;
      while ((i_req_i || d_req_i || m_busy) && n < 40) begin
         cycle();
         n++;
         if (last_i_gnt) i_req_i = 0;
         if (last_d_gnt) d_req_i = 0;
      end
      check({tag, "_drained"}, 64'(i_req_i || d_req_i || m_busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int d_at_i[3];
      int k, n;
      rst_n_i = 1; i_req_i = 0; i_addr_i = '0;
      d_req_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      mem_mode = 0; mem_fix = '0;
      model_reset(); clear_obs();
      #1 rst_n_i = 0;
      #1 check_zero("reset");
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_n_i = 1;
      @(posedge clk_i); #1;
      cycle();

      // fetch alone, immediate memory
      clear_obs(); mem_mode = 1; mem_fix = 32'h0000_0013;
      i_req_i = 1; i_addr_i = 32'h100;
      cycle();
      check("ionly_mem_req_next", mem_req_o, 1);
      check("ionly_mem_addr", mem_addr_o, 32'h100);
      cycle();
      i_req_i = 0;
      cycle();
      check("ionly_i_gnt_count", obs_i_gnt, 1);
      check("ionly_i_rv_count", obs_i_rv, 1);
      check("ionly_i_rdata", obs_i_rdata, 32'h13);
      check("ionly_d_quiet", obs_d_gnt + obs_d_rv, 0);

      // simultaneous requests: D first, then I
      clear_obs();
      i_req_i = 1; i_addr_i = 32'h400;
      d_req_i = 1; d_be_i = 4'b1111; d_addr_i = 32'h2000; d_wdata_i = 32'hCAFE_F00D;
      cycle();
      check("both_d_be", mem_be_o, 4'hF);
      check("both_d_wdata", mem_wdata_o, 32'hCAFE_F00D);
      check("both_d_addr", mem_addr_o, 32'h2000);
      cycle();
      d_req_i = 0;
      cycle();
      cycle();
      check("both_i_second_addr", mem_addr_o, 32'h400);
      check("both_i_second_be", mem_be_o, 0);
      cycle();
      i_req_i = 0;
      cycle();
      check("both_grant_counts", {obs_d_gnt[15:0], obs_i_gnt[15:0]}, {16'd1, 16'd1});

      // starvation: D held continuously, I re-requests after every grant
      clear_obs();
      d_req_i = 1; d_be_i = '0; d_addr_i = 32'h8000; i_req_i = 1; i_addr_i = 32'h1000;
      k = 0; n = 0;
      while (k < 3 && n < 80) begin
         cycle();
         n++;
         if (last_i_gnt) begin d_at_i[k] = obs_d_gnt; k++; i_addr_i = i_addr_i + 4; end
         if (last_d_gnt) d_addr_i = d_addr_i + 4;
      end
      check("starve_i_grants", k, 3);
      check("starve_d_before_first_i", d_at_i[0], 2);
      check("starve_d_before_second_i", d_at_i[1], 3);
      check("starve_d_before_third_i", d_at_i[2], 4);
      i_req_i = 0;
      drain("starve");

      // memory withholds grant for 5 cycles
      clear_obs(); mem_mode = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
      d_req_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h3000; d_wdata_i = 32'h1234_5678;
      cycle();
      for (int c = 0; c < 5; c++) begin
         d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom);
         check("hold_mem_req", mem_req_o, 1);
         check("hold_addr", mem_addr_o, 32'h3000);
         check("hold_be", mem_be_o, 4'b0011);
         check("hold_wdata", mem_wdata_o, 32'h1234_5678);
         cycle();
      end
      mem_gnt_i = 1;
      cycle();
      mem_gnt_i = 0; d_req_i = 0;
      cycle();
      mem_rvalid_i = 1; mem_rdata_i = 32'h55;
      cycle();
      mem_rvalid_i = 0;
      cycle();
      check("hold_d_gnt_once", obs_d_gnt, 1);
      check("hold_d_rv_once", obs_d_rv, 1);

      // response withheld for 20 cycles
      clear_obs();
      d_req_i = 1; d_be_i = '0; d_addr_i = 32'h500;
      cycle();
      mem_gnt_i = 1;
      cycle();
      mem_gnt_i = 0; d_req_i = 0;
      repeat (20) cycle();
`ifdef MEM_ARB_TIMEOUT_EN
      check("wd_err_once", obs_err, 1);
`else
      check("nowd_err_none", obs_err, 0);
      check("nowd_still_waiting", obs_d_rv, 0);
`endif
      mem_rvalid_i = 1; mem_rdata_i = 32'h77;
      cycle();
      mem_rvalid_i = 0;
      check("late_resp_d_rv_count", obs_d_rv, 1);
`ifdef MEM_ARB_TIMEOUT_EN
      check("wd_rdata", obs_d_rdata, 32'hDEAD_BEEF);
`else
      check("nowd_rdata", obs_d_rdata, 32'h77);
`endif

      // asynchronous reset while in RESP with a response on the bus
      clear_obs();
      d_req_i = 1; d_be_i = 4'hF; d_addr_i = 32'h600; d_wdata_i = 32'hA5A5_A5A5;
      cycle();
      mem_gnt_i = 1;
      cycle();
      mem_gnt_i = 1; d_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99;
      i_req_i = 1; i_addr_i = 32'h700;
      #1 check("pre_reset_d_rvalid", d_rvalid_o, 1);
      rst_n_i = 0;
      #1 check_zero("rst_resp");
      model_reset();
      i_req_i = 0;
      @(posedge clk_i);
      @(negedge clk_i) rst_n_i = 1;
      @(posedge clk_i); #1;
      clear_obs();
      cycle();
      cycle();
      mem_rvalid_i = 0; mem_gnt_i = 0;
      check("stray_rvalid_none", obs_i_rv + obs_d_rv, 0);

      // random traffic
      mem_mode = 2;
      for (int c = 0; c < 400; c++) begin
         if (!i_req_i && $urandom_range(0, 2) == 0) begin
            i_req_i = 1; i_addr_i = $urandom;
         end
         if (!d_req_i && $urandom_range(0, 2) == 0) begin
            d_req_i = 1; d_addr_i = $urandom; d_be_i = 4'($urandom); d_wdata_i = $urandom;
         end
         if (m_busy && !m_granted && $urandom_range(0, 3) == 0) begin
            if (m_own_i) i_addr_i = $urandom;
            else begin d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom); end
         end
         cycle();
         if (last_i_gnt) i_req_i = 0;
         if (last_d_gnt) d_req_i = 0;
      end
      drain("random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
